// File: rtl/mem_stage.sv
// Memory stage: turns EX results into bus load/store transactions and WB results.
// Alignment faults are raised locally, and flushes are absorbed without losing the bus handshake.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  exc_o,
    output logic [31:0] badvaddr_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = 2'd0;
            OP_LH, OP_LHU, OP_SH: sz = 2'd1;
            OP_LW, OP_SW:         sz = 2'd2;
            default:              sz = 2'd0;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        logic bad;
        case (op_size(op))
            2'd1:    bad = a[0];
            2'd2:    bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] v;
        case (op)
            OP_SB:   v = {4{d[7:0]}};
            OP_SH:   v = {2{d[15:0]}};
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = rd[7:0];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   v = {{24{b[7]}}, b};
            OP_LBU:  v = {24'd0, b};
            OP_LH:   v = {{16{h[15]}}, h};
            OP_LHU:  v = {16'd0, h};
            default: v = rd;
        endcase
        return v;
    endfunction

    state_t      r_state;
    logic        r_discard;
    logic [3:0]  r_op;
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic        r_valid;
    logic [4:0]  r_wd_o;
    logic        r_wreg_o;
    logic [31:0] r_wdata_o;
    logic [1:0]  r_exc;
    logic [31:0] r_badvaddr;
    logic        r_req;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_bus_wdata;

    logic        w_is_mem;
    assign w_is_mem = is_load(mem_op_i) || is_store(mem_op_i);

    // Transaction FSM; every output is registered here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_discard   <= 1'b0;
            r_op        <= 4'd0;
            r_wd        <= 5'd0;
            r_wreg      <= 1'b0;
            r_valid     <= 1'b0;
            r_wd_o      <= 5'd0;
            r_wreg_o    <= 1'b0;
            r_wdata_o   <= 32'd0;
            r_exc       <= 2'b00;
            r_badvaddr  <= 32'd0;
            r_req       <= 1'b0;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= 32'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i && !flush_i) begin
                        r_wd_o <= wd_i;
                        if (!w_is_mem) begin
                            r_valid   <= 1'b1;
                            r_wreg_o  <= wreg_i;
                            r_wdata_o <= wdata_i;
                            r_exc     <= 2'b00;
                        end else if (misaligned(mem_op_i, wdata_i[1:0])) begin
                            r_valid    <= 1'b1;
                            r_wreg_o   <= 1'b0;
                            r_wdata_o  <= wdata_i;
                            r_exc      <= is_load(mem_op_i) ? 2'b01 : 2'b10;
                            r_badvaddr <= wdata_i;
                        end else begin
                            r_state     <= S_REQ;
                            r_discard   <= 1'b0;
                            r_op        <= mem_op_i;
                            r_wd        <= wd_i;
                            r_wreg      <= wreg_i;
                            r_req       <= 1'b1;
                            r_wr        <= is_store(mem_op_i);
                            r_size      <= op_size(mem_op_i);
                            r_addr      <= wdata_i;
                            r_bus_wdata <= store_lanes(mem_op_i, reg2_i);
                        end
                    end
                end
                S_REQ: begin
                    if (data_addr_ok_i) begin
                        r_req     <= 1'b0;
                        r_state   <= S_WAIT;
                        r_discard <= flush_i;
                    end else if (flush_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok_i) begin
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                        // A flush on the completing edge discards the result as well.
                        if (!r_discard && !flush_i) begin
                            r_valid   <= 1'b1;
                            r_wd_o    <= r_wd;
                            r_wreg_o  <= is_store(r_op) ? 1'b0 : r_wreg;
                            r_wdata_o <= is_store(r_op) ? r_addr
                                         : load_extract(r_op, r_addr[1:0], data_rdata_i);
                            r_exc     <= 2'b00;
                        end
                    end else if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = (r_state == S_IDLE);
    assign stall_o      = (r_state != S_IDLE);
    assign valid_o      = r_valid;
    assign wd_o         = r_wd_o;
    assign wreg_o       = r_wreg_o;
    assign wdata_o      = r_wdata_o;
    assign exc_o        = r_exc;
    assign badvaddr_o   = r_badvaddr;
    assign data_req_o   = r_req;
    assign data_wr_o    = r_wr;
    assign data_size_o  = r_size;
    assign data_addr_o  = r_addr;
    assign data_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expected values.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  mem_op_i;
    logic [31:0] wdata_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [1:0]  exc_o;
    logic [31:0] badvaddr_o;
    logic        stall_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .mem_op_i(mem_op_i), .wdata_i(wdata_i), .reg2_i(reg2_i), .wd_i(wd_i),
        .wreg_i(wreg_i), .flush_i(flush_i), .data_req_o(data_req_o),
        .data_wr_o(data_wr_o), .data_size_o(data_size_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_addr_ok_i(data_addr_ok_i),
        .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
        .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .exc_o(exc_o), .badvaddr_o(badvaddr_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2);
        valid_i  = 1'b1;
        mem_op_i = op;
        wdata_i  = addr;
        reg2_i   = r2;
        wd_i     = 5'd7;
        wreg_i   = 1'b1;
        step();
        valid_i  = 1'b0;
    endtask

    // Full aligned transaction with immediate addr_ok and data_ok one cycle later.
    task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] r2, input logic [31:0] rdata,
                           input logic [1:0] exp_size, input logic [31:0] exp_bus_wdata);
        issue(op, addr, r2);
        check_eq({tag, "_req"}, {31'd0, data_req_o}, 32'd1);
        check_eq({tag, "_size"}, {30'd0, data_size_o}, {30'd0, exp_size});
        check_eq({tag, "_addr"}, data_addr_o, addr);
        if (op >= 4'd6) check_eq({tag, "_bwdata"}, data_wdata_o, exp_bus_wdata);
        else            check_eq({tag, "_wr"}, {31'd0, data_wr_o}, 32'd0);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b1;
        data_rdata_i   = rdata;
        step();
        data_data_ok_i = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check_eq({tag, "_exc"}, {30'd0, exc_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b0; valid_i = 1'b0; mem_op_i = 4'd0; wdata_i = 32'd0; reg2_i = 32'd0;
        wd_i = 5'd0; wreg_i = 1'b0; flush_i = 1'b0; data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0; data_rdata_i = 32'd0;
        #3;
        check_eq("rst_ready", {31'd0, ready_o}, 32'd1);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_req", {31'd0, data_req_o}, 32'd0);
        check_eq("rst_wdata", wdata_o, 32'd0);
        step();
        rst_i = 1'b1;
        step();

        // ALU pass-through
        valid_i = 1'b1; mem_op_i = 4'd0; wdata_i = 32'h12345678; wd_i = 5'd3; wreg_i = 1'b1;
        step();
        valid_i = 1'b0;
        check_eq("alu_valid", {31'd0, valid_o}, 32'd1);
        check_eq("alu_wdata", wdata_o, 32'h12345678);
        check_eq("alu_wd", {27'd0, wd_o}, 32'd3);
        check_eq("alu_wreg", {31'd0, wreg_o}, 32'd1);
        check_eq("alu_noreq", {31'd0, data_req_o}, 32'd0);
        step();
        check_eq("alu_pulse", {31'd0, valid_o}, 32'd0);

        // LB with delayed handshakes
        issue(4'd1, 32'h00001003, 32'd0);
        check_eq("lb_req", {31'd0, data_req_o}, 32'd1);
        check_eq("lb_size", {30'd0, data_size_o}, 32'd0);
        check_eq("lb_stall0", {31'd0, stall_o}, 32'd1);
        data_data_ok_i = 1'b1;
        step();
        data_data_ok_i = 1'b0;
        check_eq("lb_req_hold", {31'd0, data_req_o}, 32'd1);
        check_eq("lb_addr_hold", data_addr_o, 32'h00001003);
        check_eq("lb_ign_dok", {31'd0, valid_o}, 32'd0);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        check_eq("lb_wait_req", {31'd0, data_req_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("lb_stall", {31'd0, stall_o}, 32'd1);
            check_eq("lb_novalid", {31'd0, valid_o}, 32'd0);
        end
        data_data_ok_i = 1'b1; data_rdata_i = 32'h80FFFFFF;
        step();
        data_data_ok_i = 1'b0;
        check_eq("lb_valid", {31'd0, valid_o}, 32'd1);
        check_eq("lb_wdata", wdata_o, 32'hFFFFFF80);
        check_eq("lb_wreg", {31'd0, wreg_o}, 32'd1);
        check_eq("lb_ready", {31'd0, ready_o}, 32'd1);
        step();
        check_eq("lb_pulse", {31'd0, valid_o}, 32'd0);

        // Stores
        mem_txn("sh", 4'd7, 32'h00002002, 32'hAAAA1234, 32'd0, 2'd1, 32'h12341234);
        check_eq("sh_wreg", {31'd0, wreg_o}, 32'd0);
        mem_txn("sb", 4'd6, 32'h00005001, 32'h000000A5, 32'd0, 2'd0, 32'hA5A5A5A5);
        mem_txn("sw", 4'd8, 32'h00005004, 32'hDEADBEEF, 32'd0, 2'd2, 32'hDEADBEEF);
        check_eq("sw_wreg", {31'd0, wreg_o}, 32'd0);

        // Load extension variants
        mem_txn("lhu", 4'd4, 32'h00001002, 32'd0, 32'h80FF1234, 2'd1, 32'd0);
        check_eq("lhu_wdata", wdata_o, 32'h000080FF);
        mem_txn("lh", 4'd3, 32'h00001000, 32'd0, 32'h12348001, 2'd1, 32'd0);
        check_eq("lh_wdata", wdata_o, 32'hFFFF8001);
        mem_txn("lbu", 4'd2, 32'h00001001, 32'd0, 32'h0000F000, 2'd0, 32'd0);
        check_eq("lbu_wdata", wdata_o, 32'h000000F0);
        mem_txn("lw", 4'd5, 32'h00004000, 32'd0, 32'hCAFEBABE, 2'd2, 32'd0);
        check_eq("lw_wdata", wdata_o, 32'hCAFEBABE);

        // Misaligned accesses
        issue(4'd5, 32'h00003001, 32'd0);
        check_eq("adel_valid", {31'd0, valid_o}, 32'd1);
        check_eq("adel_exc", {30'd0, exc_o}, 32'd1);
        check_eq("adel_bad", badvaddr_o, 32'h00003001);
        check_eq("adel_wreg", {31'd0, wreg_o}, 32'd0);
        check_eq("adel_noreq", {31'd0, data_req_o}, 32'd0);
        issue(4'd8, 32'h00003002, 32'd0);
        check_eq("ades_exc", {30'd0, exc_o}, 32'd2);
        check_eq("ades_bad", badvaddr_o, 32'h00003002);
        check_eq("ades_ready", {31'd0, ready_o}, 32'd1);

        // Flush with addr_ok on the same edge
        issue(4'd5, 32'h00006000, 32'd0);
        data_addr_ok_i = 1'b1; flush_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0; flush_i = 1'b0;
        check_eq("fl_stall", {31'd0, stall_o}, 32'd1);
        check_eq("fl_req", {31'd0, data_req_o}, 32'd0);
        data_data_ok_i = 1'b1; data_rdata_i = 32'h11111111;
        step();
        data_data_ok_i = 1'b0;
        check_eq("fl_novalid", {31'd0, valid_o}, 32'd0);
        check_eq("fl_ready", {31'd0, ready_o}, 32'd1);

        // Flush in REQ withdraws the request
        issue(4'd5, 32'h00006004, 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("flr_ready", {31'd0, ready_o}, 32'd1);
        check_eq("flr_req", {31'd0, data_req_o}, 32'd0);
        check_eq("flr_novalid", {31'd0, valid_o}, 32'd0);

        // Flush in IDLE drops incoming instruction
        valid_i = 1'b1; mem_op_i = 4'd0; wdata_i = 32'h55; flush_i = 1'b1;
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        check_eq("fli_novalid", {31'd0, valid_o}, 32'd0);

        // Flush on the completing edge discards the result
        issue(4'd5, 32'h00006008, 32'd0);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b1; flush_i = 1'b1;
        step();
        data_data_ok_i = 1'b0; flush_i = 1'b0;
        check_eq("flc_novalid", {31'd0, valid_o}, 32'd0);
        check_eq("flc_ready", {31'd0, ready_o}, 32'd1);

        // Reset in the middle of WAIT
        issue(4'd5, 32'h00007000, 32'd0);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check_eq("mr_ready", {31'd0, ready_o}, 32'd1);
        check_eq("mr_addr", data_addr_o, 32'd0);
        check_eq("mr_wdata", wdata_o, 32'd0);
        check_eq("mr_bad", badvaddr_o, 32'd0);
        step();
        rst_i = 1'b1;
        data_data_ok_i = 1'b1; data_rdata_i = 32'h22222222;
        step();
        data_data_ok_i = 1'b0;
        check_eq("mr_stray", {31'd0, valid_o}, 32'd0);
        check_eq("mr_ready2", {31'd0, ready_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
